// File: rtl/stack_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : stack_pkg
//  Purpose  : Shared constants and command encoding for the operand stack of
//             the stack-based multicycle MIPS datapath.
//  Contents : C_DATA_W / C_DEPTH defaults, derived C_SP_W, stack_cmd_e
//             command type and the strobe-priority helper.
//  Revision : 1.0 - initial release
// ============================================================================
package stack_pkg;

    localparam int C_DATA_W = 8;
    localparam int C_DEPTH  = 8;
    localparam int C_SP_W   = $clog2(C_DEPTH) + 1;

    typedef enum logic [1:0] {
        CMD_NONE = 2'd0,
        CMD_PUSH = 2'd1,
        CMD_POP  = 2'd2,
        CMD_TOS  = 2'd3
    } stack_cmd_e;

    // Resolve simultaneous strobes to the one that executes: push > pop > tos.
    function automatic stack_cmd_e stack_cmd_sel(input logic push,
                                                 input logic pop,
                                                 input logic tos);
        if (push)     return CMD_PUSH;
        else if (pop) return CMD_POP;
        else if (tos) return CMD_TOS;
        else          return CMD_NONE;
    endfunction

endpackage : stack_pkg
`default_nettype wire

// File: rtl/stack_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : stack_regfile
//  Purpose  : DEPTH x DATA_W storage for the operand stack. One synchronous
//             write port, one combinational read port, async reset to zero.
//  Ports    : clk, rst           - clock / async active-high reset
//             we, waddr, wdata   - write port (captured on rising clk)
//             raddr, rdata       - combinational read port
//  Revision : 1.0 - initial release
// ============================================================================
module stack_regfile #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_mem[gi] <= '0;
                end else if (we && (waddr == AW'(gi))) begin
                    r_mem[gi] <= wdata;
                end
            end
        end
    endgenerate

    assign rdata = r_mem[raddr];

endmodule : stack_regfile
`default_nettype wire

// File: rtl/stack_unit.sv
`default_nettype none
// ============================================================================
//  Module   : stack_unit
//  Purpose  : Operand stack serving push/pop/tos/mtos strobes from the
//             multicycle controller. Registered read output, sticky error
//             flags for overflow, underflow and conflicting strobes.
//  Ports    : clk, rst              - clock / async active-high reset
//             push, pop, tos        - command strobes (push > pop > tos)
//             mtos                  - push-data select (1 mem_data, 0 alu_res)
//             alu_res, mem_data     - push data sources
//             stack_out, out_zero   - last pop/tos value and its zero flag
//             sp, empty, full       - entry count and occupancy flags
//             ovf_err, unf_err,
//             cmd_err               - sticky error flags
//  Revision : 1.0 - initial release
// ============================================================================
module stack_unit
    import stack_pkg::*;
#(
    parameter int DATA_W = C_DATA_W,
    parameter int DEPTH  = C_DEPTH,
    parameter int SP_W   = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic              tos,
    input  logic              mtos,
    input  logic [DATA_W-1:0] alu_res,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] stack_out,
    output logic              out_zero,
    output logic [SP_W-1:0]   sp,
    output logic              empty,
    output logic              full,
    output logic              ovf_err,
    output logic              unf_err,
    output logic              cmd_err
);

    localparam int              AW     = $clog2(DEPTH);
    localparam logic [SP_W-1:0] C_FULL = SP_W'(DEPTH);

    logic [SP_W-1:0]   r_sp;
    logic [DATA_W-1:0] r_stack_out;
    logic              r_ovf_err;
    logic              r_unf_err;
    logic              r_cmd_err;

    stack_cmd_e        w_cmd;
    logic              w_multi;
    logic              w_empty;
    logic              w_full;
    logic              w_we;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] w_rdata;
    logic [SP_W-1:0]   w_sp_m1;
    logic [AW-1:0]     w_waddr;
    logic [AW-1:0]     w_raddr;

    assign w_empty = (r_sp == '0);
    assign w_full  = (r_sp == C_FULL);
    assign w_cmd   = stack_cmd_sel(push, pop, tos);
    assign w_multi = (push & pop) | (push & tos) | (pop & tos);
    assign w_wdata = mtos ? mem_data : alu_res;

    // When full the low bits of sp alias slot 0, but the write is gated off.
    assign w_we    = (w_cmd == CMD_PUSH) && !w_full;
    assign w_waddr = r_sp[AW-1:0];
    assign w_sp_m1 = r_sp - SP_W'(1);
    assign w_raddr = w_sp_m1[AW-1:0];

    stack_regfile #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_regfile (
        .clk   (clk),
        .rst   (rst),
        .we    (w_we),
        .waddr (w_waddr),
        .wdata (w_wdata),
        .raddr (w_raddr),
        .rdata (w_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sp        <= '0;
            r_stack_out <= '0;
            r_ovf_err   <= 1'b0;
            r_unf_err   <= 1'b0;
            r_cmd_err   <= 1'b0;
        end else begin
            if (w_multi) begin
                r_cmd_err <= 1'b1;
            end
            case (w_cmd)
                CMD_PUSH: begin
                    if (w_full) r_ovf_err <= 1'b1;
                    else        r_sp      <= r_sp + SP_W'(1);
                end
                CMD_POP: begin
                    if (w_empty) begin
                        r_unf_err <= 1'b1;
                    end else begin
                        r_stack_out <= w_rdata;
                        r_sp        <= w_sp_m1;
                    end
                end
                CMD_TOS: begin
                    if (w_empty) r_unf_err   <= 1'b1;
                    else         r_stack_out <= w_rdata;
                end
                default: ;
            endcase
        end
    end

    assign stack_out = r_stack_out;
    assign out_zero  = (r_stack_out == '0);
    assign sp        = r_sp;
    assign empty     = w_empty;
    assign full      = w_full;
    assign ovf_err   = r_ovf_err;
    assign unf_err   = r_unf_err;
    assign cmd_err   = r_cmd_err;

endmodule : stack_unit
`default_nettype wire

// File: tb/tb_stack_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stack_unit
//  Purpose  : Self-checking bench for stack_unit: a table of directed
//             {strobes, data, expected state} records, plus hand-written
//             sequences for reset and asynchronous mid-cycle reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_stack_unit;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;
    localparam int SP_W   = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              push, pop, tos, mtos;
    logic [DATA_W-1:0] alu_res, mem_data;
    logic [DATA_W-1:0] stack_out;
    logic              out_zero;
    logic [SP_W-1:0]   sp;
    logic              empty, full, ovf_err, unf_err, cmd_err;

    int checks = 0;
    int errors = 0;

    stack_unit #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .SP_W   (SP_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .tos       (tos),
        .mtos      (mtos),
        .alu_res   (alu_res),
        .mem_data  (mem_data),
        .stack_out (stack_out),
        .out_zero  (out_zero),
        .sp        (sp),
        .empty     (empty),
        .full      (full),
        .ovf_err   (ovf_err),
        .unf_err   (unf_err),
        .cmd_err   (cmd_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        push, pop, tos, mtos;
        logic [7:0]  alu, mem;
        logic [7:0]  e_so;
        logic [3:0]  e_sp;
        logic        e_ovf, e_unf, e_cmd;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic p, input logic po, input logic t,
                                input logic m, input logic [7:0] a,
                                input logic [7:0] md, input logic [7:0] so,
                                input logic [3:0] s, input logic ov,
                                input logic un, input logic cm);
        vec_t v;
        v.push = p;  v.pop = po; v.tos = t; v.mtos = m;
        v.alu  = a;  v.mem = md;
        v.e_so = so; v.e_sp = s;
        v.e_ovf = ov; v.e_unf = un; v.e_cmd = cm;
        vecs.push_back(v);
    endfunction

    // Compares the full observable state; empty/full/out_zero follow from sp
    // and stack_out.
    task automatic check(input string nm, input logic [7:0] so,
                         input logic [3:0] s, input logic ov,
                         input logic un, input logic cm);
        logic [17:0] act, req;
        act = {stack_out, sp, empty, full, out_zero, ovf_err, unf_err, cmd_err};
        req = {so, s, (s == 4'd0), (s == 4'd8), (so == 8'h00), ov, un, cm};
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual so=%h sp=%0d e=%b f=%b z=%b ovf=%b unf=%b cmd=%b, required so=%h sp=%0d e=%b f=%b z=%b ovf=%b unf=%b cmd=%b",
                     nm, stack_out, sp, empty, full, out_zero, ovf_err, unf_err, cmd_err,
                     so, s, req[5], req[4], req[3], ov, un, cm);
        end
    endtask

    // Drive one cycle of strobes (inputs change #1 after the edge), then
    // sample #1 after the next rising edge.
    task automatic step(input logic p, input logic po, input logic t,
                        input logic m, input logic [7:0] a, input logic [7:0] md);
        push = p; pop = po; tos = t; mtos = m; alu_res = a; mem_data = md;
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0; tos = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        push = 1'b0; pop = 1'b0; tos = 1'b0; mtos = 1'b0;
        alu_res = '0; mem_data = '0;

        // --- table: push/pop/tos/mtos, alu, mem, exp so, sp, ovf, unf, cmd
        add(1,0,0,0, 8'h11, 8'h00, 8'h00, 4'd1, 0,0,0);
        add(1,0,0,1, 8'h77, 8'h22, 8'h00, 4'd2, 0,0,0);
        add(0,0,1,0, 8'h00, 8'h00, 8'h22, 4'd2, 0,0,0);
        add(0,1,0,0, 8'h00, 8'h00, 8'h22, 4'd1, 0,0,0);
        add(0,1,0,0, 8'h00, 8'h00, 8'h11, 4'd0, 0,0,0);
        for (int i = 1; i <= 8; i++)
            add(1,0,0,0, 8'(i), 8'hEE, 8'h11, 4'(i), 0,0,0);
        add(1,0,0,0, 8'h99, 8'h00, 8'h11, 4'd8, 1,0,0);
        add(0,1,0,0, 8'h00, 8'h00, 8'h08, 4'd7, 1,0,0);
        for (int i = 7; i >= 1; i--)
            add(0,1,0,0, 8'h00, 8'h00, 8'(i), 4'(i-1), 1,0,0);
        add(0,1,0,0, 8'h00, 8'h00, 8'h01, 4'd0, 1,1,0);
        add(0,0,1,0, 8'h00, 8'h00, 8'h01, 4'd0, 1,1,0);
        add(1,0,0,0, 8'h00, 8'hAA, 8'h01, 4'd1, 1,1,0);
        add(0,0,1,0, 8'h00, 8'h00, 8'h00, 4'd1, 1,1,0);
        add(1,0,0,0, 8'h05, 8'h00, 8'h00, 4'd2, 1,1,0);
        add(0,0,1,0, 8'h00, 8'h00, 8'h05, 4'd2, 1,1,0);
        add(0,1,0,0, 8'h00, 8'h00, 8'h05, 4'd1, 1,1,0);
        add(0,1,0,0, 8'h00, 8'h00, 8'h00, 4'd0, 1,1,0);
        add(1,0,0,0, 8'h33, 8'h00, 8'h00, 4'd1, 1,1,0);
        add(1,1,0,0, 8'h44, 8'h00, 8'h00, 4'd2, 1,1,1);
        add(0,0,1,0, 8'h00, 8'h00, 8'h44, 4'd2, 1,1,1);
        add(0,1,1,0, 8'h00, 8'h00, 8'h44, 4'd1, 1,1,1);
        add(0,0,1,0, 8'h00, 8'h00, 8'h33, 4'd1, 1,1,1);
        add(1,0,1,1, 8'h00, 8'h55, 8'h33, 4'd2, 1,1,1);
        add(0,0,1,0, 8'h00, 8'h00, 8'h55, 4'd2, 1,1,1);

        // --- reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_asserted", 8'h00, 4'd0, 0,0,0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("after_reset", 8'h00, 4'd0, 0,0,0);

        // --- table-driven vectors
        foreach (vecs[i]) begin
            step(vecs[i].push, vecs[i].pop, vecs[i].tos, vecs[i].mtos,
                 vecs[i].alu, vecs[i].mem);
            check($sformatf("vec%0d", i), vecs[i].e_so, vecs[i].e_sp,
                  vecs[i].e_ovf, vecs[i].e_unf, vecs[i].e_cmd);
        end

        // --- asynchronous reset between edges with data on the stack
        step(1,0,0,0, 8'hA1, 8'h00);
        step(1,0,0,0, 8'hA2, 8'h00);
        step(1,0,0,0, 8'hA3, 8'h00);
        check("three_pushes", 8'h55, 4'd5, 1,1,1);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset", 8'h00, 4'd0, 0,0,0);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        step(0,0,1,0, 8'h00, 8'h00);
        check("tos_after_reset", 8'h00, 4'd0, 0,1,0);
        step(1,0,0,0, 8'h66, 8'h00);
        check("push_after_reset", 8'h00, 4'd1, 0,1,0);
        step(0,0,1,0, 8'h00, 8'h00);
        check("tos_after_push", 8'h66, 4'd1, 0,1,0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_stack_unit
`default_nettype wire
